// File: rtl/keymgr_pkg.sv
// rtl/keymgr_pkg.sv - shared keymgr constants and sideload receiver state type
package keymgr_pkg;

    localparam int Shares         = 2;
    localparam int KeyWidth       = 16;
    localparam int DefaultMaxUses = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNMASK = 2'd1,
        READY  = 2'd2,
        WIPE   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/keymgr_unmask_acc.sv
// rtl/keymgr_unmask_acc.sv - serial XOR unmask datapath for sideload keys
//
// Holds the latched shares and folds them one per cycle into an accumulator.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : latch all shares, acc = share 0, index = 1
//   step_i       : acc ^= share[index], index++
//   wipe_i       : zero shares, accumulator and index
//   shares_i     : packed shares, share s at [s*KeyWidth +: KeyWidth]
//   acc_o        : accumulator contents
//   last_o       : the current step folds the final share
module keymgr_unmask_acc
    import keymgr_pkg::*;
#(
    parameter int NumShares = Shares,
    parameter int KeyW      = KeyWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic                      step_i,
    input  logic                      wipe_i,
    input  logic [NumShares*KeyW-1:0] shares_i,
    output logic [KeyW-1:0]           acc_o,
    output logic                      last_o
);

    localparam int IdxW = $clog2(NumShares + 1);

    logic [KeyW-1:0] share_q [NumShares];
    logic [KeyW-1:0] share_d [NumShares];
    logic [KeyW-1:0] acc_q, acc_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [KeyW-1:0] sel_share;

    // Mux by comparison keeps the index width independent of the array size.
    always_comb begin
        sel_share = '0;
        for (int s = 0; s < NumShares; s++) begin
            if (idx_q == IdxW'(s)) begin
                sel_share = share_q[s];
            end
        end
    end

    always_comb begin
        share_d = share_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        if (wipe_i) begin
            for (int s = 0; s < NumShares; s++) begin
                share_d[s] = '0;
            end
            acc_d = '0;
            idx_d = '0;
        end else if (load_i) begin
            for (int s = 0; s < NumShares; s++) begin
                share_d[s] = shares_i[s*KeyW +: KeyW];
            end
            acc_d = shares_i[KeyW-1:0];
            idx_d = IdxW'(1);
        end else if (step_i) begin
            acc_d = acc_q ^ sel_share;
            idx_d = idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < NumShares; s++) begin
                share_q[s] <= '0;
            end
            acc_q <= '0;
            idx_q <= '0;
        end else begin
            share_q <= share_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (idx_q == IdxW'(NumShares - 1));

endmodule

// File: rtl/keymgr_sideload_rx.sv
// rtl/keymgr_sideload_rx.sv - keymgr sideload key receiver with serial unmask
//
// Optional feature macro: KEYMGR_RX_USE_CNT_EN (use counter with expiry).
//   clk_i, rst_i : clock, synchronous active-high reset
//   key_valid_i  : sender holds high while shares are valid
//   key_share_i  : packed shares, share s at [s*KeyWidth +: KeyWidth]
//   clear_i      : pulse to drop the key
//   key_use_i    : consumer pulse, one use of the key
//   key_o        : unmasked key, zero unless key_vld_o
//   key_vld_o    : key_o is valid
//   expired_o    : one-cycle pulse when the use limit is reached
module keymgr_sideload_rx
    import keymgr_pkg::*;
#(
    parameter int Shares   = keymgr_pkg::Shares,
    parameter int KeyWidth = keymgr_pkg::KeyWidth,
    parameter int MaxUses  = DefaultMaxUses
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       key_valid_i,
    input  logic [Shares*KeyWidth-1:0] key_share_i,
    input  logic                       clear_i,
    input  logic                       key_use_i,
    output logic [KeyWidth-1:0]        key_o,
    output logic                       key_vld_o,
    output logic                       expired_o
);

    rx_state_e         state_q, state_d;
    logic              armed_q, armed_d;
    logic [KeyWidth-1:0] key_q, key_d;
    logic              key_vld_q, key_vld_d;
    logic              load, step, wipe;
    logic [KeyWidth-1:0] acc;
    logic              last;
    logic              use_expire;
    logic              drop;

    keymgr_unmask_acc #(
        .NumShares (Shares),
        .KeyW      (KeyWidth)
    ) u_unmask_acc (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load),
        .step_i   (step),
        .wipe_i   (wipe),
        .shares_i (key_share_i),
        .acc_o    (acc),
        .last_o   (last)
    );

    assign drop = !key_valid_i || clear_i;

`ifdef KEYMGR_RX_USE_CNT_EN
    localparam int CntW = $clog2(MaxUses + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            expired_q, expired_d;

    // The final use still reports expiry even when a drop/clear wins the exit.
    always_comb begin
        cnt_d      = cnt_q;
        expired_d  = 1'b0;
        use_expire = 1'b0;
        if (state_q == WIPE) begin
            cnt_d = '0;
        end else if (state_q == READY && key_use_i) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_d == CntW'(MaxUses)) begin
                expired_d  = 1'b1;
                use_expire = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;
`else
    logic unused_key_use;
    assign unused_key_use = key_use_i;
    assign use_expire     = 1'b0;
    assign expired_o      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        load    = 1'b0;
        step    = 1'b0;
        wipe    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Clear blocks capture; a held-high valid after a wipe stays
                // disarmed until valid is seen low here.
                if (key_valid_i && armed_q && !clear_i) begin
                    load    = 1'b1;
                    armed_d = 1'b0;
                    state_d = UNMASK;
                end else if (!key_valid_i) begin
                    armed_d = 1'b1;
                end
            end
            UNMASK: begin
                if (drop) begin
                    state_d = WIPE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (drop || use_expire) begin
                    state_d = WIPE;
                end
            end
            WIPE: begin
                wipe    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs register one cycle after READY is entered and clear on the same
    // edge that leaves READY.
    always_comb begin
        key_vld_d = (state_q == READY) && (state_d == READY);
        key_d     = key_vld_d ? acc : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            armed_q   <= 1'b1;
            key_q     <= '0;
            key_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            key_q     <= key_d;
            key_vld_q <= key_vld_d;
        end
    end

    assign key_o     = key_q;
    assign key_vld_o = key_vld_q;

endmodule
